riscv_commit_trace_streamer: RTL
================================

Name: riscv_commit_trace_streamer

Overview:
- Sits directly downstream of riscv_multicycle and consumes its per-instruction commit outputs (update/pc/instr/reg/mem).
- Buffers each commit record in a FIFO, then serializes it as a variable-length stream of XLEN-bit words over a valid/ready interface.
- The stream feeds a trace sink (log writer, UART bridge, debug RAM).
- Counts and flags records lost to back-pressure, so the sink can detect gaps.

Parameters:
- XLEN, 32, word width; matches riscv_pkg::XLEN.
- DEPTH, 8, FIFO depth in records; power of two, >= 2.
- DROP_CNT_W, 16, width of the dropped-record counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- update_i  in  1  commit strobe; one record per cycle in which it is high.
- pc_i  in  XLEN  committed PC.
- instr_i  in  XLEN  committed instruction.
- reg_addr_i  in  5  destination register; 0 means no writeback.
- reg_data_i  in  XLEN  writeback data.
- mem_wrt_i  in  1  store committed.
- mem_addr_i  in  XLEN  store address.
- mem_data_i  in  XLEN  store data.
- word_o  out  XLEN  stream word.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  sink accepts word_o.
- last_o  out  1  word_o is the final word of its record.
- overflow_o  out  1  sticky: at least one record dropped since reset.
- drop_cnt_o  out  DROP_CNT_W  records dropped, saturating.
- fifo_level_o  out  $clog2(DEPTH)+1  records currently held in the FIFO.

Behaviour:
- Reset (rst_i=1 at an edge):
  - FIFO emptied; FSM returns to IDLE.
  - word_valid_o=0, last_o=0, word_o=0.
  - overflow_o=0, drop_cnt_o=0, fifo_level_o=0, sequence counter=0.
  - Reset mid-record abandons the record; no partial words follow reset.
- Capture:
  - Each cycle with update_i=1, an 8-bit sequence number seq is assigned; seq increments on every update_i, whether the record is kept or dropped.
  - If fifo_level < DEPTH, the record {seq, pc, instr, reg_addr, reg_data, mem_wrt, mem_addr, mem_data} is written.
  - Otherwise the record is dropped: drop_cnt_o increments (saturates at all-ones) and overflow_o is set.
  - Full is evaluated on the registered level. A pop in the same cycle does not free a slot for that cycle's push.
- Header word:
  - [31:24] = 8'hA5
  - [23:16] = seq
  - [12:8] = reg_addr
  - [2] = (reg_addr != 0)
  - [1] = mem_wrt
  - [0] = 1
  - All other bits 0.
- Record word order:
  - HDR, PC, INSTR, always.
  - RD (reg_data) only if reg_addr != 0.
  - MADDR then MDATA only if mem_wrt = 1.
  - Length is 3 to 6 words.
- FSM states: IDLE, HDR, PC, INSTR, RD, MADDR, MDATA.
  - IDLE: if the FIFO is non-empty, pop the head into a shadow register and go to HDR. word_valid_o is high from HDR onward.
  - A state advances only on word_valid_o && word_ready_i. Skipped words are bypassed (INSTR->MADDR, INSTR->IDLE, RD->IDLE, ...).
  - last_o is high in the state emitting the final word of the record.
  - On acceptance of a last word with the FIFO non-empty: pop and go straight to HDR, with no bubble cycle. Otherwise go to IDLE.
- Latency: update_i high in cycle N into an empty, idle block gives word_valid_o with the header in cycle N+2.
- Stream stability: while word_valid_o=1 and word_ready_i=0, word_o and last_o hold stable. word_valid_o never drops before acceptance.
- fifo_level_o reflects pushes and pops registered at the prior edge. The shadow register is not counted.
- Throughput: sustained 1 word/cycle with word_ready_i tied high.

Test Plan:
- Reset, then one update with pc=0x80000000, instr=0x00500093, reg_addr=1, reg_data=5, mem_wrt=0, ready=1 -> 4 words starting at N+2: 0xA5000105, 0x80000000, 0x00500093, 0x00000005; last_o only on the 4th.
- Store with reg_addr=0, mem_wrt=1, mem_addr=0x80000010, mem_data=0xDEADBEEF -> header 0xA5000003, PC, INSTR, 0x80000010, 0xDEADBEEF; 5 words, no RD word.
- ready=0, then 12 consecutive updates with DEPTH=8 -> fifo_level_o=8; 3 records dropped (first popped into shadow, 8 stored, rest dropped); drop_cnt_o=3, overflow_o=1; after ready=1, header seq fields read 0..8, with gap visible.
- ready toggling 1010... during a 6-word record -> word_o and last_o hold stable while ready=0; all 6 words delivered in order exactly once.
- Two back-to-back records, ready=1 -> last word of record 1 is immediately followed by header of record 2 with no gap; word_valid_o stays continuously high.
- rst_i asserted during the MADDR word, with 3 records queued -> next cycle word_valid_o=0, fifo_level_o=0, drop_cnt_o=0; next update gets seq=0.

Source files
------------

// File: rtl/riscv_commit_trace_streamer_if.sv
// Valid/ready stream carrying serialized commit-trace words toward a trace sink.
interface riscv_commit_trace_streamer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [XLEN-1:0] word;
  logic            word_valid;
  logic            word_ready;
  logic            last;

  modport master (
    output word,
    output word_valid,
    output last,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    input  last,
    output word_ready
  );
endinterface

// File: rtl/riscv_commit_trace_streamer.sv
// Buffers commit records from the core in a FIFO and serializes each one as a
// 3..6 word trace stream, counting records lost while the FIFO is full.
module riscv_commit_trace_streamer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       mem_wrt_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_data_i,
  riscv_commit_trace_streamer_if.master trace_io,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [7:0]      seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      ra;
    logic [XLEN-1:0] rd;
    logic            mw;
    logic [XLEN-1:0] ma;
    logic [XLEN-1:0] md;
  } rec_t;

  typedef enum logic [2:0] {
    StIdle, StHdr, StPc, StInstr, StRd, StMaddr, StMdata
  } state_e;

  rec_t                  mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [7:0]            seq_q;
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  ovf_q;

  state_e          st_q, st_d;
  rec_t            rec_q, rec_d;
  logic [XLEN-1:0] word_q, word_d;
  logic            valid_q, last_q, last_d;

  rec_t in_rec;
  logic full, push, pop, adv, has_rec, done;

  assign in_rec  = '{seq: seq_q, pc: pc_i, instr: instr_i, ra: reg_addr_i, rd: reg_data_i,
                     mw: mem_wrt_i, ma: mem_addr_i, md: mem_data_i};
  // Full uses the registered level: a same-cycle pop never makes room for a push.
  assign full    = (level_q == LW'(DEPTH));
  assign push    = update_i & ~full;
  assign has_rec = (level_q != '0);
  assign adv     = valid_q & trace_io.word_ready;

  always_comb begin
    st_d  = st_q;
    rec_d = rec_q;
    pop   = 1'b0;
    done  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (has_rec) begin
          pop   = 1'b1;
          rec_d = mem_q[rd_ptr_q];
          st_d  = StHdr;
        end
      end
      StHdr:   if (adv) st_d = StPc;
      StPc:    if (adv) st_d = StInstr;
      StInstr: begin
        if (adv) begin
          if (rec_q.ra != 5'd0) st_d = StRd;
          else if (rec_q.mw)    st_d = StMaddr;
          else                  done = 1'b1;
        end
      end
      StRd: begin
        if (adv) begin
          if (rec_q.mw) st_d = StMaddr;
          else          done = 1'b1;
        end
      end
      StMaddr: if (adv) st_d = StMdata;
      StMdata: if (adv) done = 1'b1;
      default: st_d = StIdle;
    endcase
    // Chain straight into the next header so back-to-back records have no bubble.
    if (done) begin
      if (has_rec) begin
        pop   = 1'b1;
        rec_d = mem_q[rd_ptr_q];
        st_d  = StHdr;
      end else begin
        st_d  = StIdle;
      end
    end
  end

  always_comb begin
    word_d = '0;
    last_d = 1'b0;
    unique case (st_d)
      StHdr: word_d = XLEN'({8'hA5, rec_d.seq, 3'b000, rec_d.ra, 5'b00000,
                             (rec_d.ra != 5'd0), rec_d.mw, 1'b1});
      StPc:  word_d = rec_d.pc;
      StInstr: begin
        word_d = rec_d.instr;
        last_d = (rec_d.ra == 5'd0) && !rec_d.mw;
      end
      StRd: begin
        word_d = rec_d.rd;
        last_d = !rec_d.mw;
      end
      StMaddr: word_d = rec_d.ma;
      StMdata: begin
        word_d = rec_d.md;
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q     <= StIdle;
      rec_q    <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      rec_q   <= rec_d;
      word_q  <= word_d;
      last_q  <= last_d;
      valid_q <= (st_d != StIdle);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
      if (update_i) seq_q <= seq_q + 8'd1;
      if (update_i && full) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= in_rec;
  end

  assign trace_io.word       = word_q;
  assign trace_io.word_valid = valid_q;
  assign trace_io.last       = last_q;
  assign overflow_o          = ovf_q;
  assign drop_cnt_o          = drop_q;
  assign fifo_level_o        = level_q;

endmodule
